// File: rtl/run_length_detector_if.sv
// rtl/run_length_detector_if.sv - stream input and run report bundle for run_length_detector
interface run_length_detector_if #(
  parameter int CNT_W   = 4,
  parameter int MAX_RUN = (1 << CNT_W) - 1
);
  logic               in_valid;
  logic               x;
  logic               polarity;
  logic               flush;
  logic [MAX_RUN:0]   match_mask;
  logic               y;
  logic               run_valid;
  logic [CNT_W-1:0]   run_len;
  logic               sat_seen;

  modport master (
    output in_valid, x, polarity, flush, match_mask,
    input  y, run_valid, run_len, sat_seen
  );

  modport slave (
    input  in_valid, x, polarity, flush, match_mask,
    output y, run_valid, run_len, sat_seen
  );
endinterface

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - serial run-length detector with saturation, polarity and mask match
module run_length_detector #(
  parameter int CNT_W   = 4,
  parameter int MAX_RUN = (1 << CNT_W) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  run_length_detector_if.slave  bus
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SAT} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             pol_q, pol_d;
  logic             y_q, y_d;
  logic             run_valid_q, run_valid_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             sat_seen_q, sat_seen_d;
  logic             run_bit, non_run, term;

  always_comb begin
    state = S_IDLE;
    if (cnt_q == MAX_C)
      state = S_SAT;
    else if (cnt_q != '0)
      state = S_RUN;

    // Run membership uses the polarity latched before this edge.
    run_bit = bus.in_valid && (bus.x == pol_q);
    non_run = bus.in_valid && (bus.x != pol_q);

    cnt_next = cnt_q;
    if (run_bit && (state != S_SAT))
      cnt_next = cnt_q + 1'b1;

    // A bit counted in the same cycle as flush belongs to the terminated run.
    term = (cnt_next != '0) && (non_run || bus.flush);

    pol_d       = (state == S_IDLE) ? bus.polarity : pol_q;
    sat_seen_d  = sat_seen_q || (cnt_next == MAX_C);
    run_len_d   = run_len_q;
    run_valid_d = 1'b0;
    y_d         = 1'b0;
    cnt_d       = cnt_next;
    if (term) begin
      run_valid_d = 1'b1;
      run_len_d   = cnt_next;
      y_d         = bus.match_mask[cnt_next];
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      pol_q       <= 1'b1;
      y_q         <= 1'b0;
      run_valid_q <= 1'b0;
      run_len_q   <= '0;
      sat_seen_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pol_q       <= pol_d;
      y_q         <= y_d;
      run_valid_q <= run_valid_d;
      run_len_q   <= run_len_d;
      sat_seen_q  <= sat_seen_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.run_valid = run_valid_q;
  assign bus.run_len   = run_len_q;
  assign bus.sat_seen  = sat_seen_q;
endmodule
